// File: rtl/net_pkg.sv
// Shared packet definitions for the GPU network transmit path.
// Packet layout is {dest_gpu, payload}.
package net_pkg;

   localparam int PKT_W     = 16;
   localparam int DEST_W    = 6;
   localparam int PAYLOAD_W = 10;

   typedef struct packed {
      logic [DEST_W-1:0]    dest;
      logic [PAYLOAD_W-1:0] payload;
   } net_pkt_t;

   function automatic logic [DEST_W-1:0] pkt_dest(input logic [PKT_W-1:0] pkt);
      return pkt[PKT_W-1 -: DEST_W];
   endfunction

   function automatic logic [PAYLOAD_W-1:0] pkt_payload(input logic [PKT_W-1:0] pkt);
      return pkt[PAYLOAD_W-1:0];
   endfunction

endpackage

// File: rtl/net_tx_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first request at or after ptr
// (wrapping modulo NUM_REQ) wins; one-hot grant plus encoded index.
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [2:0]         ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [2:0]         grant_idx,
   output logic               grant_any
);

   logic [7:0] req_ext_s;
   logic [3:0] cand_s;

   always_comb begin
      req_ext_s              = 8'd0;
      req_ext_s[NUM_REQ-1:0] = req;
      cand_s                 = 4'd0;
      grant_idx              = 3'd0;
      grant_any              = 1'b0;
      grant                  = {NUM_REQ{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         cand_s = {1'b0, ptr} + 4'(i);
         if (cand_s >= 4'(NUM_REQ)) begin
            cand_s = cand_s - 4'(NUM_REQ);
         end else begin
            cand_s = cand_s;
         end
         if (!grant_any && req_ext_s[cand_s[2:0]]) begin
            grant_any = 1'b1;
            grant_idx = cand_s[2:0];
         end else begin
            grant_any = grant_any;
         end
      end
      for (int g = 0; g < NUM_REQ; g++) begin
         grant[g] = grant_any && (grant_idx == 3'(g));
      end
   end

endmodule

// File: rtl/net_tx_arbiter.sv
// Round-robin share of the GPU network transmit port: one registered output
// slot, loopback of self-addressed packets, packet counters, stall watchdog.
module net_tx_arbiter
   import net_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int GPU_ID  = 21,
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 16
) (
   input  logic                     ACLK,
   input  logic                     ARESET,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [PKT_W*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [PKT_W-1:0]         net_data_out,
   output logic                     net_valid_out,
   input  logic                     net_ready_in,
   output logic [PAYLOAD_W-1:0]     loop_data,
   output logic                     loop_valid,
   output logic [2:0]               grant_id,
   output logic [CNT_W-1:0]         sent_cnt,
   output logic [CNT_W-1:0]         loop_cnt,
   output logic                     stall_err
);

   localparam int              WD_W    = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   logic               slot_free_s;
   logic               stalled_s;
   logic               accept_s;
   logic               is_loop_s;
   logic [NUM_REQ-1:0] req_gated_s;
   logic [NUM_REQ-1:0] grant_s;
   logic [2:0]         win_idx_s;
   logic [2:0]         rr_ptr_r;
   logic [PKT_W-1:0]   req_pkt_s [8];
   net_pkt_t           win_pkt_s;
   logic [WD_W-1:0]    wd_cnt_r;

   // Unpack the flat request bus into an 8-entry table so a 3-bit index can select it.
   generate
      for (genvar g = 0; g < 8; g++) begin : g_pkt
         if (g < NUM_REQ) begin : g_used
            assign req_pkt_s[g] = req_data[PKT_W*g +: PKT_W];
         end else begin : g_pad
            assign req_pkt_s[g] = {PKT_W{1'b0}};
         end
      end
   endgenerate

   always_comb begin
      slot_free_s = !net_valid_out || net_ready_in;
      stalled_s   = net_valid_out && !net_ready_in;
      req_gated_s = req_valid & {NUM_REQ{slot_free_s}};
      win_pkt_s   = req_pkt_s[win_idx_s];
      is_loop_s   = (pkt_dest(win_pkt_s) == DEST_W'(GPU_ID));
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .req       (req_gated_s),
      .ptr       (rr_ptr_r),
      .grant     (grant_s),
      .grant_idx (win_idx_s),
      .grant_any (accept_s)
   );

   assign req_ready = grant_s;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         rr_ptr_r <= 3'd0;
         grant_id <= 3'd0;
      end else if (accept_s) begin
         rr_ptr_r <= (win_idx_s == 3'(NUM_REQ - 1)) ? 3'd0 : win_idx_s + 3'd1;
         grant_id <= win_idx_s;
      end else begin
         rr_ptr_r <= rr_ptr_r;
         grant_id <= grant_id;
      end
   end

   // A free slot refills from a non-loop winner or empties; a held packet stays put.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         net_valid_out <= 1'b0;
         net_data_out  <= {PKT_W{1'b0}};
      end else if (slot_free_s) begin
         net_valid_out <= accept_s && !is_loop_s;
         if (accept_s && !is_loop_s) begin
            net_data_out <= win_pkt_s;
         end else begin
            net_data_out <= net_data_out;
         end
      end else begin
         net_valid_out <= net_valid_out;
         net_data_out  <= net_data_out;
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         loop_valid <= 1'b0;
         loop_data  <= {PAYLOAD_W{1'b0}};
         loop_cnt   <= {CNT_W{1'b0}};
      end else if (accept_s && is_loop_s) begin
         loop_valid <= 1'b1;
         loop_data  <= pkt_payload(win_pkt_s);
         loop_cnt   <= loop_cnt + CNT_W'(1);
      end else begin
         loop_valid <= 1'b0;
         loop_data  <= loop_data;
         loop_cnt   <= loop_cnt;
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         sent_cnt <= {CNT_W{1'b0}};
      end else if (net_valid_out && net_ready_in) begin
         sent_cnt <= sent_cnt + CNT_W'(1);
      end else begin
         sent_cnt <= sent_cnt;
      end
   end

   // wd_cnt_r holds the number of stalled cycles so far; the TIMEOUT-th one sets stall_err.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         wd_cnt_r  <= {WD_W{1'b0}};
         stall_err <= 1'b0;
      end else if (stalled_s) begin
         if (wd_cnt_r == WD_LAST) begin
            wd_cnt_r  <= wd_cnt_r;
            stall_err <= 1'b1;
         end else begin
            wd_cnt_r  <= wd_cnt_r + WD_W'(1);
            stall_err <= stall_err;
         end
      end else begin
         wd_cnt_r  <= {WD_W{1'b0}};
         stall_err <= stall_err;
      end
   end

endmodule

// File: doc/net_tx_arbiter.md
Name: net_tx_arbiter

Overview:
- Round-robin arbiter that shares one GPU's 16-bit network-interface transmit port between NUM_REQ local requesters (AXI master bridge, test traffic, DMA, and so on).
- Packet format is {dest_gpu[5:0], payload[9:0]}.
- Holds one registered output packet with valid/ready backpressure.
- Diverts self-addressed packets to a local loopback port and flags a stalled network with a watchdog.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GPU_ID, 21, this GPU's 6-bit network ID, used for loopback detection.
- TIMEOUT, 1024, cycles net_valid_out may stay high without net_ready_in before stall_err sets.
- CNT_W, 16, width of the sent/looped packet counters.

Ports:
- ACLK  in  1  clock, rising edge.
- ARESET  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester packet valid.
- req_data  in  16*NUM_REQ  per-requester packet; requester i occupies bits [16i+15:16i].
- req_ready  out  NUM_REQ  one-hot grant/accept, combinational.
- net_data_out  out  16  packet to the NI.
- net_valid_out  out  1  output packet valid.
- net_ready_in  in  1  NI accepts the packet.
- loop_data  out  10  payload of a self-addressed packet.
- loop_valid  out  1  one-cycle pulse, loopback delivery.
- grant_id  out  3  index of the last granted requester.
- sent_cnt  out  CNT_W  packets accepted by the NI.
- loop_cnt  out  CNT_W  packets delivered via loopback.
- stall_err  out  1  sticky watchdog error.

Behaviour:
- Reset (async, ARESET=1): all outputs 0, rr_ptr=0, watchdog counter=0.
- Output slot is "free" when net_valid_out=0, or when net_valid_out=1 and net_ready_in=1 (same-cycle refill allowed).
- Arbitration, evaluated combinationally each cycle the slot is free:
  - Search req_valid starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first set bit, index w, wins and req_ready[w]=1; every other req_ready bit is 0.
  - req_ready is all-zero when the slot is not free.
- On accept of requester w (req_valid[w] && req_ready[w]):
  - rr_ptr <= (w+1) mod NUM_REQ.
  - grant_id <= w.
- Destination not self (req_data[15:10] != GPU_ID):
  - Next cycle net_data_out = packet and net_valid_out = 1.
  - Latency is 1 cycle from accept.
- Destination is self (req_data[15:10] == GPU_ID):
  - Packet never reaches the network.
  - Next cycle loop_valid = 1 for exactly 1 cycle, with loop_data = payload; loop_cnt increments.
  - If the slot was emptied the same cycle, net_valid_out drops to 0.
- Output hold:
  - While net_valid_out=1 and net_ready_in=0, net_data_out is stable and nobody is granted.
  - On net_ready_in=1: sent_cnt increments; the slot either refills from a new grant the same cycle or clears net_valid_out.
  - Sustained throughput is 1 packet/cycle with net_ready_in tied high.
- No valid requests with a free slot: net_valid_out <= 0; rr_ptr unchanged.
- Counters wrap at 2^CNT_W - 1 to 0 silently.
- Watchdog:
  - Counter increments each cycle net_valid_out=1 && net_ready_in=0.
  - Clears on any NI accept or when net_valid_out=0.
  - When it reaches TIMEOUT, stall_err <= 1. stall_err is sticky until reset.
  - The stuck packet is not dropped.
- Reset mid-transfer: a held packet is discarded; net_valid_out drops asynchronously.
- Requesters must hold req_valid/req_data stable until accepted. Withdrawing early is a protocol violation and is not checked.

Decomposition:
- Shared package net_pkg holds:
  - PKT_W=16, DEST_W=6, PAYLOAD_W=10.
  - Field slice functions pkt_dest() and pkt_payload().
  - Packet struct typedef net_pkt_t.
- One sub-module: rr_arbiter (NUM_REQ request vector + pointer in, one-hot grant + encoded index out, purely combinational).
- The top level holds the output register, loopback, counters and watchdog.

Test Plan:
- Single request: req0 sends 16'h5923 (dest 22) with net_ready_in=1. Expect net_data_out=16'h5923 and net_valid_out one cycle after req_ready[0]. sent_cnt=1, grant_id=0.
- Fairness: all 4 req_valid held high, net_ready_in=1. Grants rotate 0,1,2,3,0,… one per cycle, with no requester granted twice before the others.
- Backpressure: packet pending with net_ready_in=0 for 10 cycles. net_data_out stays stable, req_ready=0 throughout. Raising ready gives accept plus same-cycle refill from the next requester.
- Loopback: req2 sends 16'h5555 (dest 21 = GPU_ID). Expect loop_valid pulse with loop_data=10'h155, loop_cnt=1, net_valid_out=0, sent_cnt unchanged.
- Watchdog: TIMEOUT=8, net_ready_in=0 with a packet held. stall_err=0 through cycle 7 of the stall and 1 from cycle 8. It stays 1 after a later accept and clears only on ARESET.
- Async reset mid-hold: assert ARESET between clock edges while a packet is held. Expect immediate net_valid_out=0, cleared counters, and rr_ptr=0, so the next grant goes to req0.
